// File: rtl/interleaved_buck_pulse_gen.sv
// Interleaved multi-phase buck pulse generator for discharge machining.
// Sequences breakdown wait, interleaved current-regulated discharge and
// deionisation, and provides per-phase dead time and overcurrent shutdown.
module interleaved_buck_pulse_gen #(
  parameter int unsigned N_PHASE     = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEAD_TIME   = 10,
  parameter int unsigned WAIT_BD_MIN = 300,
  parameter int unsigned WAIT_BD_MAX = 10000,
  parameter int unsigned BD_CUR      = 5,
  parameter int unsigned BD_VOL      = 30,
  parameter int unsigned I_LIMIT     = 80,
  parameter int unsigned INTERLEAVE  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   ton,
  input  logic [CNT_W-1:0]   toff,
  input  logic [CNT_W-1:0]   ip,
  input  logic               single_mode,
  input  logic               fire,
  input  logic [15:0]        sample_current,
  input  logic [15:0]        sample_voltage,
  output logic [N_PHASE-1:0] mosfet_upper,
  output logic [N_PHASE-1:0] mosfet_lower,
  output logic               mosfet_deion,
  output logic               busy,
  output logic               is_breakdown,
  output logic               pulse_done,
  output logic               open_pulse,
  output logic               fault
);

  localparam int unsigned SMP_W     = 16;
  localparam int unsigned CMP_W     = (CNT_W > SMP_W) ? CNT_W : SMP_W;
  localparam int unsigned DT_LOAD_I = (DEAD_TIME > 0) ? DEAD_TIME - 1 : 0;
  localparam int unsigned BD_LAST_I = (WAIT_BD_MAX > 0) ? WAIT_BD_MAX - 1 : 0;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DT_LOAD_C = CNT_W'(DT_LOAD_I);
  localparam logic [CNT_W-1:0] BD_MIN_C  = CNT_W'(WAIT_BD_MIN);
  localparam logic [CNT_W-1:0] BD_LAST_C = CNT_W'(BD_LAST_I);
  localparam logic [SMP_W-1:0] BD_CUR_C  = SMP_W'(BD_CUR);
  localparam logic [SMP_W-1:0] BD_VOL_C  = SMP_W'(BD_VOL);
  localparam logic [SMP_W-1:0] I_LIM_C   = SMP_W'(I_LIMIT);

  typedef enum logic [2:0] {
    IDLE, ARMED, WAIT_BD, DISCHARGE, DEION, FAULT
  } state_t;

  typedef enum logic [1:0] {REQ_OFF, REQ_UP, REQ_LO} req_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   tmr, tmr_n;
  logic [CNT_W-1:0]   ton_sh, toff_sh, ip_sh;
  logic [CNT_W-1:0]   ton_act, toff_act, ip_act;
  logic               load_act;
  logic               oc, bd_hit, below_ip;

  req_t               req_q [N_PHASE];
  req_t               req_n [N_PHASE];
  req_t               want  [N_PHASE];
  logic [CNT_W-1:0]   dt_q  [N_PHASE];
  logic [CNT_W-1:0]   dt_n  [N_PHASE];

  logic [N_PHASE-1:0] upper_n, lower_n;
  logic               deion_n, busy_n, bd_n, done_n, open_n, fault_n;

  // Analog compare decisions on the current samples
  assign oc       = (sample_current > I_LIM_C);
  assign bd_hit   = (tmr >= BD_MIN_C) && (sample_current >= BD_CUR_C) &&
                    (sample_voltage <= BD_VOL_C);
  assign below_ip = (CMP_W'(sample_current) < CMP_W'(ip_act));

  // Next-state decision; stop beats overcurrent beats everything else
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = single_mode ? ARMED : WAIT_BD;
      ARMED:     if (fire) state_n = WAIT_BD;
      WAIT_BD: begin
        if (bd_hit)                 state_n = DISCHARGE;
        else if (tmr >= BD_LAST_C)  state_n = DEION;
      end
      DISCHARGE: if (tmr >= ton_act - CNT_W'(1)) state_n = DEION;
      DEION:     if (tmr >= toff_act - CNT_W'(1)) state_n = single_mode ? IDLE : WAIT_BD;
      FAULT:     state_n = FAULT;
      default:   state_n = IDLE;
    endcase
    if (oc && (state != IDLE) && (state != FAULT)) state_n = FAULT;
    if (stop) state_n = IDLE;
  end

  // Shared saturating state timer and next-cycle status flags
  always_comb begin
    tmr_n    = '0;
    load_act = 1'b0;
    if (state_n == state) tmr_n = (tmr == CNT_MAX) ? tmr : tmr + CNT_W'(1);
    load_act = (state_n == WAIT_BD) && (state != WAIT_BD);
    busy_n   = (state_n != IDLE);
    deion_n  = (state_n == DEION) || (state_n == FAULT);
    fault_n  = (state_n == FAULT);
    bd_n     = (state == WAIT_BD) && (state_n == DISCHARGE);
    open_n   = (state == WAIT_BD) && (state_n == DEION);
    done_n   = (state == DISCHARGE) && (state_n == DEION);
  end

  // Per-phase request and dead-time insertion on every upper/lower swap
  always_comb begin
    upper_n = '0;
    lower_n = '0;
    for (int k = 0; k < int'(N_PHASE); k++) begin
      want[k]  = REQ_OFF;
      req_n[k] = REQ_OFF;
      dt_n[k]  = '0;
      if ((state_n == WAIT_BD) && (k == 0)) begin
        want[k] = REQ_UP;
      end else if ((state_n == DISCHARGE) &&
                   (tmr_n >= CNT_W'(k * int'(INTERLEAVE)))) begin
        want[k] = below_ip ? REQ_UP : REQ_LO;
      end
      req_n[k] = want[k];
      if (want[k] != REQ_OFF) begin
        if ((req_q[k] != REQ_OFF) && (want[k] != req_q[k]) && (DEAD_TIME != 0)) begin
          dt_n[k] = DT_LOAD_C;
        end else if (dt_q[k] != '0) begin
          dt_n[k] = dt_q[k] - CNT_W'(1);
        end else begin
          upper_n[k] = (want[k] == REQ_UP);
          lower_n[k] = (want[k] == REQ_LO);
        end
      end
    end
  end

  // State, timers, settings and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmr          <= '0;
      ton_sh       <= CNT_W'(1);
      toff_sh      <= CNT_W'(1);
      ip_sh        <= '0;
      ton_act      <= CNT_W'(1);
      toff_act     <= CNT_W'(1);
      ip_act       <= '0;
      mosfet_upper <= '0;
      mosfet_lower <= '0;
      mosfet_deion <= 1'b0;
      busy         <= 1'b0;
      is_breakdown <= 1'b0;
      pulse_done   <= 1'b0;
      open_pulse   <= 1'b0;
      fault        <= 1'b0;
      for (int k = 0; k < int'(N_PHASE); k++) begin
        req_q[k] <= REQ_OFF;
        dt_q[k]  <= '0;
      end
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      if (cfg_valid) begin
        ton_sh  <= ton;
        toff_sh <= toff;
        ip_sh   <= ip;
      end
      if (load_act) begin
        ton_act  <= (ton_sh == '0) ? CNT_W'(1) : ton_sh;
        toff_act <= (toff_sh == '0) ? CNT_W'(1) : toff_sh;
        ip_act   <= ip_sh;
      end
      mosfet_upper <= upper_n;
      mosfet_lower <= lower_n;
      mosfet_deion <= deion_n;
      busy         <= busy_n;
      is_breakdown <= bd_n;
      pulse_done   <= done_n;
      open_pulse   <= open_n;
      fault        <= fault_n;
      for (int k = 0; k < int'(N_PHASE); k++) begin
        req_q[k] <= req_n[k];
        dt_q[k]  <= dt_n[k];
      end
    end
  end

endmodule

// File: tb/tb_interleaved_buck_pulse_gen.sv
// Bench for interleaved_buck_pulse_gen: vector table for control corner cases,
// timed event scoreboard for breakdown/open/done pulses, dead-time monitor.
module tb_interleaved_buck_pulse_gen;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 16;
  localparam int EV_DONE = 1;
  localparam int EV_OPEN = 2;
  localparam int EV_BD   = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop, cfg_valid, single_mode, fire;
  logic [CW-1:0] ton, toff, ip;
  logic [15:0]   cur, vol;
  logic [NP-1:0] up, lo;
  logic          deion, busy, is_bd, done, open_p, fault;

  interleaved_buck_pulse_gen #(.N_PHASE(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_valid(cfg_valid),
    .ton(ton), .toff(toff), .ip(ip), .single_mode(single_mode), .fire(fire),
    .sample_current(cur), .sample_voltage(vol),
    .mosfet_upper(up), .mosfet_lower(lo), .mosfet_deion(deion), .busy(busy),
    .is_breakdown(is_bd), .pulse_done(done), .open_pulse(open_p), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int cyc; } ev_t;
  typedef struct {
    bit start; bit stop; bit fire; bit single;
    int cur;   int vol;  int exp;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  vec_t vt [12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   dt_en = 1'b0;
  int   last_on [NP];
  int   off_run [NP];
  int   swaps;

  function automatic int mk(int b, int u, int l, int d, int f);
    return (b << 13) | (u << 9) | (l << 5) | (d << 4) | (f << 3);
  endfunction

  function automatic int outs();
    return int'({busy, up, lo, deion, fault, is_bd, open_p, done});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    int on;
    @(posedge clk);
    #1;
    cyc++;
    if (is_bd)  obs_q.push_back('{EV_BD, cyc});
    if (open_p) obs_q.push_back('{EV_OPEN, cyc});
    if (done)   obs_q.push_back('{EV_DONE, cyc});
    if (dt_en) begin
      check("both_on", int'(up & lo), 0);
      for (int k = 0; k < int'(NP); k++) begin
        on = up[k] ? 1 : (lo[k] ? 2 : 0);
        if (on == 0) begin
          off_run[k]++;
        end else begin
          if (last_on[k] != 0 && on != last_on[k]) begin
            swaps++;
            check($sformatf("dead_time_ph%0d", k), off_run[k], 10);
          end
          last_on[k] = on;
          off_run[k] = 0;
        end
      end
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_cfg(input int t, input int f, input int i);
    ton = CW'(t); toff = CW'(f); ip = CW'(i);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    ev_t e, o;
    check({tag, "_events"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_ev_kind"}, o.code, e.code);
      check({tag, "_ev_cycle"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0, e2, e3;
    // start stop fire single cur vol expected
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  0, 100, 0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 100, 0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0, 100, 0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1,  0, 100, mk(1, 0, 0, 0, 0)};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1,  0, 100, mk(1, 0, 0, 0, 0)};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0, 100, mk(1, 1, 0, 0, 0)};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1,  0, 100, mk(1, 1, 0, 0, 0)};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 81, 100, mk(1, 0, 0, 1, 1)};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 100, mk(1, 0, 0, 1, 1)};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,  0, 100, 0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 100, mk(1, 1, 0, 0, 0)};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 81, 100, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; single_mode = 1'b0;
    fire = 1'b0; ton = '0; toff = '0; ip = '0; cur = '0; vol = 16'd100;
    tick();
    tick();
    check("reset_outputs", outs(), 0);
    rst = 1'b0;

    // control-path vectors
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start; stop = vt[i].stop; fire = vt[i].fire;
      single_mode = vt[i].single; cur = 16'(vt[i].cur); vol = 16'(vt[i].vol);
      tick();
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
    end
    start = 1'b0; stop = 1'b0; fire = 1'b0; single_mode = 1'b0; cur = '0; vol = 16'd100;
    tick();
    obs_q.delete();
    exp_q.delete();

    // continuous mode: late breakdown, interleaved enables, deion, return
    set_cfg(50, 100, 20);
    start = 1'b1; tick(); start = 1'b0;
    e0 = cyc;
    check("a_wait_entry", outs(), mk(1, 1, 0, 0, 0));
    run_to(e0 + 400);
    cur = 16'd10; vol = 16'd20;
    exp_q.push_back('{EV_BD, e0 + 401});
    exp_q.push_back('{EV_DONE, e0 + 451});
    tick();
    check("a_bd_entry", outs(), mk(1, 1, 0, 0, 0) | EV_BD);
    vol = 16'd100;
    run_to(e0 + 403); check("a_ph_plus2", int'(up), 4'b0001);
    tick();           check("a_ph_plus3", int'(up), 4'b0011);
    run_to(e0 + 406); check("a_ph_plus5", int'(up), 4'b0011);
    tick();           check("a_ph_plus6", int'(up), 4'b0111);
    run_to(e0 + 409); check("a_ph_plus8", int'(up), 4'b0111);
    tick();           check("a_ph_plus9", int'(up), 4'b1111);
    run_to(e0 + 450); check("a_dis_last", outs(), mk(1, 15, 0, 0, 0));
    tick();           check("a_done", outs(), mk(1, 0, 0, 1, 0) | EV_DONE);
    run_to(e0 + 550); check("a_deion_last", outs(), mk(1, 0, 0, 1, 0));
    tick();           check("a_rewait", outs(), mk(1, 1, 0, 0, 0));

    // open pulse after the full wait window
    e2 = cyc;
    exp_q.push_back('{EV_OPEN, e2 + 10000});
    run_to(e2 + 9999); check("b_wait_last", outs(), mk(1, 1, 0, 0, 0));
    tick();            check("b_open", outs(), mk(1, 0, 0, 1, 0) | EV_OPEN);
    run_to(e2 + 10099);
    tick();
    e3 = cyc;
    check("b_rewait", outs(), mk(1, 1, 0, 0, 0));

    // early breakdown stimulus held off until the minimum wait
    run_to(e3 + 200);
    vol = 16'd20;
    exp_q.push_back('{EV_BD, e3 + 301});
    exp_q.push_back('{EV_DONE, e3 + 351});
    run_to(e3 + 300); check("c_still_wait", outs(), mk(1, 1, 0, 0, 0));
    tick();           check("c_bd_at_min", outs(), mk(1, 1, 0, 0, 0) | EV_BD);
    vol = 16'd100;
    run_to(e3 + 360);
    stop = 1'b1; tick(); stop = 1'b0;
    check("c_stop_in_deion", outs(), 0);
    drain("ac");

    // dead time on current-driven swaps, then overcurrent in discharge
    set_cfg(200, 5, 20);
    cur = 16'd10; vol = 16'd20;
    start = 1'b1; tick(); start = 1'b0;
    e0 = cyc;
    exp_q.push_back('{EV_BD, e0 + 301});
    run_to(e0 + 301);
    vol = 16'd100;
    swaps = 0;
    for (int k = 0; k < int'(NP); k++) begin
      last_on[k] = 0;
      off_run[k] = 0;
    end
    dt_en = 1'b1;
    run_to(e0 + 316); check("d_all_upper", outs(), mk(1, 15, 0, 0, 0));
    cur = 16'd30;
    run_to(e0 + 336); check("d_all_lower", outs(), mk(1, 0, 15, 0, 0));
    cur = 16'd10;
    run_to(e0 + 356);
    dt_en = 1'b0;
    check("d_swaps", swaps, 8);
    cur = 16'd81; tick();
    check("e_fault", outs(), mk(1, 0, 0, 1, 1));
    cur = 16'd0; start = 1'b1; tick(); start = 1'b0;
    check("e_start_ignored", outs(), mk(1, 0, 0, 1, 1));
    stop = 1'b1; tick(); stop = 1'b0;
    check("e_stop_idle", outs(), 0);
    drain("de");

    // single-discharge mode
    set_cfg(20, 30, 20);
    single_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("f_armed", outs(), mk(1, 0, 0, 0, 0));
    cur = 16'd10; vol = 16'd20;
    fire = 1'b1; tick(); fire = 1'b0;
    e0 = cyc;
    check("f_fired", outs(), mk(1, 1, 0, 0, 0));
    exp_q.push_back('{EV_BD, e0 + 301});
    exp_q.push_back('{EV_DONE, e0 + 321});
    run_to(e0 + 325);
    fire = 1'b1; tick(); fire = 1'b0;
    run_to(e0 + 350); check("f_deion_last", outs(), mk(1, 0, 0, 1, 0));
    tick();           check("f_idle", outs(), 0);
    run_to(e0 + 400); check("f_stays_idle", outs(), 0);
    drain("f");

    // reset mid-pulse, then zero ton/toff treated as one cycle
    single_mode = 1'b0;
    set_cfg(100, 10, 20);
    start = 1'b1; tick(); start = 1'b0;
    e0 = cyc;
    exp_q.push_back('{EV_BD, e0 + 301});
    run_to(e0 + 315); check("g_mid_pulse", outs(), mk(1, 15, 0, 0, 0));
    rst = 1'b1; tick(); rst = 1'b0;
    check("g_reset_clears", outs(), 0);
    drain("g1");
    set_cfg(0, 0, 20);
    start = 1'b1; tick(); start = 1'b0;
    e0 = cyc;
    exp_q.push_back('{EV_BD, e0 + 301});
    exp_q.push_back('{EV_DONE, e0 + 302});
    run_to(e0 + 301); check("g_ton0_dis", outs(), mk(1, 1, 0, 0, 0) | EV_BD);
    tick();           check("g_toff0_deion", outs(), mk(1, 0, 0, 1, 0) | EV_DONE);
    tick();           check("g_rewait", outs(), mk(1, 1, 0, 0, 0));
    stop = 1'b1; tick(); stop = 1'b0;
    check("g_stop", outs(), 0);
    drain("g2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interleaved_buck_pulse_gen.md
INTERLEAVED_BUCK_PULSE_GEN -- requirements
Module: interleaved_buck_pulse_gen

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): N_PHASE, 2, number of interleaved buck phases, legal 1..4.
REQ-002 The block SHALL have parameter CNT_W, 16, width of every timer and setting.
REQ-003 The block SHALL have parameter DEAD_TIME, 10, cycles between a phase's upper-off and lower-on, and between lower-off and upper-on.
REQ-004 The block SHALL have parameters WAIT_BD_MIN, 300, and WAIT_BD_MAX, 10000: the breakdown wait window in cycles.
REQ-005 The block SHALL have parameters BD_CUR, 5, and BD_VOL, 30: breakdown thresholds in A and V.
REQ-006 The block SHALL have parameters I_LIMIT, 80, overcurrent trip in A, and INTERLEAVE, 3, phase-to-phase enable delay in cycles.
REQ-007 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- start, stop  in  1 each  one-cycle machine start/stop strobes.
- cfg_valid  in  1  capture ton, toff, ip into shadow registers.
- ton, toff, ip  in  CNT_W each  on-time (cycles), off-time (cycles), current setpoint (A).
- single_mode  in  1  1 = one pulse per fire strobe.
- fire  in  1  single-discharge trigger strobe.
- sample_current, sample_voltage  in  16 each  unsigned, already in clk domain.
- mosfet_upper, mosfet_lower  out  N_PHASE each  per-phase gate drives.
- mosfet_deion  out  1  deionisation switch.
- busy, is_breakdown, pulse_done, open_pulse, fault  out  1 each  status.

Function
REQ-008 The FSM SHALL have states IDLE, ARMED, WAIT_BD, DISCHARGE, DEION and FAULT.
REQ-009 In IDLE, start SHALL set busy and move to WAIT_BD if single_mode=0, otherwise to ARMED.
REQ-010 In ARMED, fire SHALL move to WAIT_BD; fire in any other state SHALL be ignored.
REQ-011 On WAIT_BD entry, the active Ton/Toff/Ip SHALL load from the shadow registers; cfg_valid SHALL only write the shadow registers, in any state.
REQ-012 A latched ton or toff of 0 SHALL be treated as 1.
REQ-013 In WAIT_BD, mosfet_upper[0] SHALL be 1 and all other gates 0, and a CNT_W wait counter SHALL increment from 0.
REQ-014 Breakdown SHALL be detected when wait counter >= WAIT_BD_MIN, sample_current >= BD_CUR and sample_voltage <= BD_VOL in the same cycle; the FSM SHALL then go to DISCHARGE and pulse is_breakdown for one cycle.
REQ-015 If the wait counter reaches WAIT_BD_MAX without breakdown, the FSM SHALL go to DEION and pulse open_pulse for one cycle.
REQ-016 DISCHARGE SHALL last exactly Ton cycles, counted from the entry cycle.
REQ-017 In DISCHARGE, phase k SHALL be enabled k*INTERLEAVE cycles after entry; phase 0 stays driven continuously from WAIT_BD.
REQ-018 An enabled phase SHALL request upper when sample_current < Ip and lower otherwise.
REQ-019 A per-phase dead-time counter SHALL hold both gates at 0 for DEAD_TIME cycles on every change of request.
- mosfet_upper[k] and mosfet_lower[k] SHALL never be 1 together.
REQ-020 At Ton expiry, all gates SHALL go to 0, the FSM SHALL move to DEION, and pulse_done SHALL pulse for one cycle.
REQ-021 DEION SHALL last Toff cycles with mosfet_deion=1 and all buck gates at 0.
- On exit: WAIT_BD if single_mode=0, otherwise IDLE with busy=0.
REQ-022 sample_current > I_LIMIT in any state other than IDLE and FAULT SHALL cause, in the next cycle: FAULT, all buck gates 0, mosfet_deion=1, fault=1.
REQ-023 FAULT SHALL be left only by stop, which SHALL go to IDLE.
REQ-024 In any state, stop SHALL force IDLE in the next cycle with all gates 0 and busy=0.
- stop SHALL win over a simultaneous start, fire, overcurrent or Ton/Toff expiry.
REQ-025 Overcurrent SHALL win over breakdown or timer expiry in the same cycle.
REQ-026 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 All outputs SHALL be registered; a gate SHALL change one cycle after the FSM/compare decision that causes it.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL be in IDLE.
- All outputs 0.
- Shadow ton=1, toff=1, ip=0.
- All counters 0.
REQ-029 rst asserted mid-pulse SHALL clear all gates at the next edge, regardless of state.

Verification
REQ-030 Continuous mode (ton=50, toff=100, ip=20): after start, hold voltage 100 / current 0 for 400 cycles, then voltage 20 / current 10 -> is_breakdown, 50-cycle DISCHARGE, 100-cycle deion, return to WAIT_BD.
REQ-031 Voltage stays 100 -> open_pulse exactly 10000 cycles after WAIT_BD entry, then DEION.
REQ-032 Breakdown stimulus at wait count 200 -> ignored until count 300.
REQ-033 N_PHASE=4: phase enables at +0/+3/+6/+9 cycles; current toggles across ip -> every upper/lower swap shows 10 cycles with both gates 0, never both 1.
REQ-034 sample_current=81 during DISCHARGE -> FAULT next cycle with deion=1; start is ignored; stop returns to IDLE.
REQ-035 single_mode=1: start then fire -> exactly one pulse, then IDLE; a second fire during DEION is ignored; start+stop in the same cycle -> remains IDLE.
